// File: rtl/lift_call_dispatcher.sv
// Lift call dispatcher: latches hall and cabin calls for floors 1..FLOORS and
// issues one target floor at a time to the lift controller using SCAN ordering.
// Optional feature macro: LIFT_DISPATCH_RETARGET_EN. When it is defined, a new
// request between the car and the current target replaces the target while it
// is being issued.
module lift_call_dispatcher #(
    parameter int unsigned FLOORS  = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] hall_req_i,
    input  logic [FLOORS-1:0] cab_req_i,
    input  logic [2:0]        elev_f_i,
    input  logic              arrive_i,
    output logic [2:0]        target_o,
    output logic              target_valid_o,
    output logic              target_src_o,
    output logic [1:0]        dir_o,
    output logic [FLOORS-1:0] pending_o,
    output logic              fault_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSelect = 2'd1;
    localparam logic [1:0] StIssue  = 2'd2;
    localparam logic [1:0] StHold   = 2'd3;

    localparam logic [1:0] DirNone = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirDn   = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [FLOORS-1:0] hall_p_q, hall_p_d;
    logic [FLOORS-1:0] cab_p_q, cab_p_d;
    logic [2:0]        target_q, target_d;
    logic [1:0]        dir_q, dir_d;
    logic              src_q, src_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              fault_q, fault_d;

    logic [FLOORS-1:0] pend;
    logic [FLOORS-1:0] clr_mask;
    int                car;
    int                up_f;
    int                dn_f;
    int                sel_f;
    logic [1:0]        sel_dir;
    logic              sel_valid;
`ifdef LIFT_DISPATCH_RETARGET_EN
    int                rt_f;
`endif

    assign pend = hall_p_q | cab_p_q;

    // Pending bitmaps: arrival clears the car's floor, a same-cycle press re-sets it.
    always_comb begin
        clr_mask = '0;
        for (int f = 0; f < int'(FLOORS); f++) begin
            clr_mask[f] = arrive_i && (int'(elev_f_i) == f + 1);
        end
        hall_p_d = (hall_p_q & ~clr_mask) | hall_req_i;
        cab_p_d  = (cab_p_q & ~clr_mask) | cab_req_i;
    end

    // SCAN selection: here, ahead, behind (reversing), else nearest with ties up.
    always_comb begin
        car = int'(elev_f_i);
        if (car == 0 || car > int'(FLOORS)) car = 1;
        up_f = 0;
        dn_f = 0;
        for (int f = int'(FLOORS); f >= 1; f--) begin
            if (f > car && pend[f-1]) up_f = f;
        end
        for (int f = 1; f <= int'(FLOORS); f++) begin
            if (f < car && pend[f-1]) dn_f = f;
        end
        sel_valid = 1'b1;
        sel_f     = car;
        sel_dir   = dir_q;
        if (pend[car-1]) begin
            sel_f = car;
        end else if (dir_q == DirUp && up_f != 0) begin
            sel_f = up_f;
        end else if (dir_q == DirDn && dn_f != 0) begin
            sel_f = dn_f;
        end else if (dir_q == DirUp && dn_f != 0) begin
            sel_f   = dn_f;
            sel_dir = DirDn;
        end else if (dir_q == DirDn && up_f != 0) begin
            sel_f   = up_f;
            sel_dir = DirUp;
        end else if (up_f != 0 && (dn_f == 0 || (up_f - car) <= (car - dn_f))) begin
            sel_f   = up_f;
            sel_dir = DirUp;
        end else if (dn_f != 0) begin
            sel_f   = dn_f;
            sel_dir = DirDn;
        end else begin
            sel_valid = 1'b0;
        end
    end

`ifdef LIFT_DISPATCH_RETARGET_EN
    // Nearest fresh request strictly between the car and the target, in travel direction.
    always_comb begin
        rt_f = 0;
        if (dir_q == DirUp) begin
            for (int f = int'(FLOORS); f >= 1; f--) begin
                if ((hall_req_i[f-1] || cab_req_i[f-1]) && f > car && f < int'(target_q)) rt_f = f;
            end
        end else if (dir_q == DirDn) begin
            for (int f = 1; f <= int'(FLOORS); f++) begin
                if ((hall_req_i[f-1] || cab_req_i[f-1]) && f < car && f > int'(target_q)) rt_f = f;
            end
        end
    end
`endif

    // Dispatcher FSM and timeout supervision.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        unique case (state_q)
            StIdle: begin
                dir_d = DirNone;
                if (!fault_q && pend != '0) state_d = StSelect;
            end
            StSelect: begin
                if (sel_valid) begin
                    target_d = 3'(sel_f);
                    dir_d    = sel_dir;
                    cnt_d    = 8'd0;
                    state_d  = StIssue;
                end else begin
                    dir_d   = DirNone;
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (arrive_i && elev_f_i == target_q) begin
                    state_d = StHold;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    dir_d   = DirNone;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`ifdef LIFT_DISPATCH_RETARGET_EN
                    if (rt_f != 0) begin
                        target_d = 3'(rt_f);
                        cnt_d    = 8'd0;
                    end
`endif
                end
            end
            default: state_d = StSelect;
        endcase
    end

    // Source flag tracks the cab bit of the target while it is being issued.
    always_comb begin
        src_d = src_q;
        if (state_d == StIssue) src_d = cab_p_d[int'(target_d) - 1];
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hall_p_q <= '0;
            cab_p_q  <= '0;
            target_q <= 3'd1;
            dir_q    <= DirNone;
            src_q    <= 1'b0;
            cnt_q    <= 8'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hall_p_q <= hall_p_d;
            cab_p_q  <= cab_p_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    assign target_o       = target_q;
    assign target_valid_o = (state_q == StIssue);
    assign target_src_o   = src_q;
    assign dir_o          = dir_q;
    assign pending_o      = pend;
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_lift_call_dispatcher.sv
// Self-checking bench for lift_call_dispatcher: expected targets are queued when
// requests are driven and compared whenever target_valid_o rises.
module tb_lift_call_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] hall_req_i;
    logic [6:0] cab_req_i;
    logic [2:0] elev_f_i;
    logic       arrive_i;
    logic [2:0] target_o;
    logic       target_valid_o;
    logic       target_src_o;
    logic [1:0] dir_o;
    logic [6:0] pending_o;
    logic       fault_o;

    typedef struct packed {
        logic [2:0] tgt;
        logic [1:0] dir;
        logic       src;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    lift_call_dispatcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hall_req_i    (hall_req_i),
        .cab_req_i     (cab_req_i),
        .elev_f_i      (elev_f_i),
        .arrive_i      (arrive_i),
        .target_o      (target_o),
        .target_valid_o(target_valid_o),
        .target_src_o  (target_src_o),
        .dir_o         (dir_o),
        .pending_o     (pending_o),
        .fault_o       (fault_o)
    );

    // Scoreboard: every fresh target issue is compared against the queued expectation.
    always @(negedge clk) begin
        if (target_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: target=%0d dir=%b src=%b but no target expected",
                         target_o, dir_o, target_src_o);
            end else begin
                e = exp_q.pop_front();
                if ({target_o, dir_o, target_src_o} !== {e.tgt, e.dir, e.src}) begin
                    errors++;
                    $display("FAIL sb_target: got target=%0d dir=%b src=%b, want target=%0d dir=%b src=%b",
                             target_o, dir_o, target_src_o, e.tgt, e.dir, e.src);
                end
            end
        end
        prev_valid = target_valid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic [1:0] d, input logic s);
        exp_t x;
        x.tgt = t;
        x.dir = d;
        x.src = s;
        exp_q.push_back(x);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (target_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (target_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: target_valid_o=%b after %0d cycles, want 1", name, target_valid_o, n);
        end
    endtask

    task automatic arrive_at(input logic [2:0] f);
        elev_f_i = f;
        arrive_i = 1'b1;
        tick();
        arrive_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({target_o, target_valid_o, target_src_o, dir_o, pending_o, fault_o} !==
            {3'd1, 1'b0, 1'b0, 2'b00, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got tgt=%0d v=%b src=%b dir=%b pend=%b fault=%b, want 1 0 0 00 0000000 0",
                     target_o, target_valid_o, target_src_o, dir_o, pending_o, fault_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_call();
        elev_f_i   = 3'd1;
        hall_req_i = 7'b0010000;
        push(3'd5, 2'b01, 1'b0);
        tick();
        hall_req_i = '0;
        checks++;
        if (pending_o !== 7'b0010000 || target_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: pend=%b v=%b, want 0010000 0", pending_o, target_valid_o);
        end
        tick();
        checks++;
        if (target_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_select: v=%b, want 0", target_valid_o);
        end
        tick();
        checks++;
        if (target_valid_o !== 1'b1 || target_o !== 3'd5) begin
            errors++;
            $display("FAIL single_issue: v=%b tgt=%0d, want 1 5", target_valid_o, target_o);
        end
        arrive_at(3'd5);
        checks++;
        if (target_valid_o !== 1'b0 || pending_o !== 7'd0) begin
            errors++;
            $display("FAIL single_arrive: v=%b pend=%b, want 0 0000000", target_valid_o, pending_o);
        end
        tick();
        tick();
        tick();
        checks++;
        if (target_valid_o !== 1'b0 || dir_o !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: v=%b dir=%b, want 0 00", target_valid_o, dir_o);
        end
    endtask

    task automatic test_scan();
        elev_f_i  = 3'd1;
        cab_req_i = 7'b0001000;
        push(3'd4, 2'b01, 1'b1);
        tick();
        cab_req_i = '0;
        wait_valid("scan_first");
        elev_f_i   = 3'd4;
        hall_req_i = 7'b0000010;
        cab_req_i  = 7'b0100000;
        push(3'd6, 2'b01, 1'b1);
        push(3'd2, 2'b10, 1'b0);
        tick();
        hall_req_i = '0;
        cab_req_i  = '0;
        checks++;
        if (pending_o !== 7'b0101010) begin
            errors++;
            $display("FAIL scan_pending: pend=%b, want 0101010", pending_o);
        end
        arrive_at(3'd4);
        wait_valid("scan_up");
        arrive_at(3'd6);
        wait_valid("scan_reverse");
        arrive_at(3'd2);
        checks++;
        if (pending_o !== 7'd0) begin
            errors++;
            $display("FAIL scan_clear: pend=%b, want 0000000", pending_o);
        end
        tick();
        tick();
        tick();
        checks++;
        if (target_valid_o !== 1'b0 || dir_o !== 2'b00) begin
            errors++;
            $display("FAIL scan_idle: v=%b dir=%b, want 0 00", target_valid_o, dir_o);
        end
    endtask

    task automatic test_set_wins();
        cab_req_i = 7'b0000100;
        push(3'd3, 2'b01, 1'b1);
        tick();
        cab_req_i = '0;
        wait_valid("setwin_first");
        elev_f_i  = 3'd3;
        arrive_i  = 1'b1;
        cab_req_i = 7'b0000100;
        push(3'd3, 2'b01, 1'b1);
        tick();
        arrive_i  = 1'b0;
        cab_req_i = '0;
        checks++;
        if (pending_o !== 7'b0000100 || target_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL setwin_pending: pend=%b v=%b, want 0000100 0", pending_o, target_valid_o);
        end
        wait_valid("setwin_reissue");
        arrive_at(3'd3);
        tick();
        tick();
        tick();
        checks++;
        if (pending_o !== 7'd0 || target_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL setwin_clear: pend=%b v=%b, want 0000000 0", pending_o, target_valid_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        hall_req_i = 7'b1000000;
        push(3'd7, 2'b01, 1'b0);
        tick();
        hall_req_i = '0;
        wait_valid("timeout_issue");
        n = 1;
        while (target_valid_o === 1'b1 && n < 400) begin
            tick();
            if (target_valid_o === 1'b1) n++;
        end
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL timeout_len: valid cycles=%0d, want 255", n);
        end
        checks++;
        if (fault_o !== 1'b1 || target_valid_o !== 1'b0 || pending_o !== 7'b1000000) begin
            errors++;
            $display("FAIL timeout_fault: fault=%b v=%b pend=%b, want 1 0 1000000",
                     fault_o, target_valid_o, pending_o);
        end
        hall_req_i = 7'b0000010;
        tick();
        hall_req_i = '0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (fault_o !== 1'b1 || target_valid_o !== 1'b0 || pending_o !== 7'b1000010) begin
            errors++;
            $display("FAIL timeout_stuck: fault=%b v=%b pend=%b, want 1 0 1000010",
                     fault_o, target_valid_o, pending_o);
        end
    endtask

    task automatic test_reset_mid_issue();
        test_reset();
        elev_f_i   = 3'd1;
        hall_req_i = 7'b0010000;
        push(3'd5, 2'b01, 1'b0);
        tick();
        hall_req_i = '0;
        wait_valid("rst_issue");
        cab_req_i = 7'b1000000;
        tick();
        cab_req_i = '0;
        rst_n     = 1'b0;
        tick();
        checks++;
        if ({target_o, target_valid_o, target_src_o, dir_o, pending_o, fault_o} !==
            {3'd1, 1'b0, 1'b0, 2'b00, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: got tgt=%0d v=%b src=%b dir=%b pend=%b fault=%b, want 1 0 0 00 0000000 0",
                     target_o, target_valid_o, target_src_o, dir_o, pending_o, fault_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (target_valid_o !== 1'b0 || pending_o !== 7'd0) begin
            errors++;
            $display("FAIL rst_after: v=%b pend=%b, want 0 0000000", target_valid_o, pending_o);
        end
    endtask

    task automatic test_retarget();
        elev_f_i  = 3'd2;
        cab_req_i = 7'b0100000;
        push(3'd6, 2'b01, 1'b1);
        tick();
        cab_req_i = '0;
        wait_valid("rt_issue");
        cab_req_i = 7'b0001000;
        tick();
        cab_req_i = '0;
`ifdef LIFT_DISPATCH_RETARGET_EN
        checks++;
        if (target_o !== 3'd4 || target_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rt_switch: tgt=%0d v=%b, want 4 1", target_o, target_valid_o);
        end
        push(3'd6, 2'b01, 1'b1);
        arrive_at(3'd4);
        wait_valid("rt_resume");
        arrive_at(3'd6);
`else
        tick();
        tick();
        checks++;
        if (target_o !== 3'd6 || target_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rt_hold: tgt=%0d v=%b, want 6 1", target_o, target_valid_o);
        end
        push(3'd4, 2'b10, 1'b1);
        arrive_at(3'd6);
        wait_valid("rt_next");
        arrive_at(3'd4);
`endif
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pending_o !== 7'd0 || target_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rt_clear: pend=%b v=%b, want 0000000 0", pending_o, target_valid_o);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        hall_req_i = '0;
        cab_req_i  = '0;
        elev_f_i   = 3'd1;
        arrive_i   = 1'b0;
        test_reset();
        test_single_call();
        test_scan();
        test_set_wins();
        test_timeout();
        test_reset_mid_issue();
        test_retarget();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected targets never issued, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_call_dispatcher.md
# lift_call_dispatcher

Upstream request stage for the lift controller: latches hall-call and cabin-button presses for floors 1..7 into pending bitmaps and selects one target floor at a time using a SCAN (continue-in-direction) policy. It presents that floor to the controller's floor inputs and holds it until the controller reports arrival. On arrival it clears the served request, then selects the next target.

## Interface
- FLOORS, 7, number of served floors; floor numbers 1..FLOORS fit in 3 bits.
- TIMEOUT, 255, cycles `target_valid_o` may stay high without arrival before fault.
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- hall_req_i  in  FLOORS  hall-call press; bit k = floor k+1; level or pulse, sampled every cycle
- cab_req_i  in  FLOORS  cabin-button press; same encoding
- elev_f_i  in  3  current car floor (1..FLOORS) from lift controller
- arrive_i  in  1  one-cycle pulse: car stopped, doors opening at `elev_f_i`
- target_o  out  3  selected target floor
- target_valid_o  out  1  `target_o` is valid and held stable
- target_src_o  out  1  0 = only hall call pending at target, 1 = cab request pending at target
- dir_o  out  2  00 none, 01 up, 10 down
- pending_o  out  FLOORS  OR of hall and cab pending bitmaps
- fault_o  out  1  sticky; set on arrival timeout, cleared only by reset

## Operation
- Pending registers `hall_p`, `cab_p`: each cycle, bits set by OR with the inputs and cleared by serve.
  - Set wins over clear on the same bit in the same cycle.
- Serve on `arrive_i`: clears `hall_p` and `cab_p` bits for `elev_f_i` in any state.
- States: IDLE, SELECT, ISSUE, HOLD.
- IDLE:
  - `target_valid_o`=0 and `dir_o`=00.
  - If `pending_o`≠0 -> SELECT.
- SELECT (exactly one cycle); priority order:
  1. Request at `elev_f_i` -> target = `elev_f_i`, `dir_o` unchanged.
  2. Else nearest pending floor in current direction.
  3. Else reverse direction and take the nearest pending floor.
  4. Else, with `dir_o`=00, take the nearest floor, ties to up.
  - None pending -> IDLE. Otherwise register `target_o` and `dir_o` -> ISSUE.
- ISSUE:
  - `target_valid_o`=1.
  - `arrive_i` with `elev_f_i`==`target_o` -> HOLD.
  - `arrive_i` at another floor -> clear that floor only, stay in ISSUE.
- HOLD (one cycle): `target_valid_o`=0 -> SELECT.
- `target_src_o` = `cab_p[target_o-1]`, updated every cycle in ISSUE.
- Timeout counter: 8-bit, cleared on entering ISSUE, increments while in ISSUE.
  - Reaching TIMEOUT -> `fault_o`=1, `target_valid_o`=0 -> IDLE; pending bitmaps are kept.
  - When `fault_o`=1, IDLE does not leave until reset.
- `elev_f_i` of 0 or >FLOORS is treated as floor 1 for selection.

## Timing
- Reset values: `target_o`=3'd1, `target_valid_o`=0, `target_src_o`=0, `dir_o`=00, `pending_o`=0, `fault_o`=0, state IDLE, counter 0.
- A request pulse at cycle N appears in `pending_o` at N+1.
  - From IDLE, SELECT runs at N+2 and `target_valid_o`=1 at N+3.
- Arrival pulse at cycle M:
  - Bit cleared in `pending_o` at M+1; `target_valid_o` low at M+1 (HOLD).
  - Next target valid at M+3 if requests remain.
- `target_o` must not change while `target_valid_o`=1, except under the configuration macro.
- Reset mid-ISSUE: all outputs return to reset values at the next edge and pending requests are lost.

## Configuration
- `LIFT_DISPATCH_RETARGET_EN` defined:
  - In ISSUE, a new request strictly between `elev_f_i` and `target_o` in the current direction replaces `target_o` on the next cycle.
  - `target_valid_o` stays 1 and the timeout counter restarts.
  - The previous target stays pending.
- Not defined: the target is held until arrival or timeout, and new requests are only latched.

## Test plan
- Reset, `elev_f_i`=1, pulse `hall_req_i`=7'b0010000 (floor 5) -> `target_o`=5, `target_valid_o`=1 three cycles later, `dir_o`=01, `target_src_o`=0.
- Car at 4 moving up, pending floors 2 and 6 -> first target 6; after arrival at 6 -> target 2, `dir_o`=10; `pending_o`=0 after arrival at 2.
- `arrive_i` at floor 3 while target 3, same cycle as `cab_req_i` floor 3 -> bit 3 stays set in `pending_o`, next target 3.
- Target 7, no `arrive_i` for 255 cycles -> `fault_o`=1, `target_valid_o`=0, `pending_o` still shows floor 7, stays IDLE.
- With `LIFT_DISPATCH_RETARGET_EN`: car at 2, target 6, cab press floor 4 -> `target_o`=4 next cycle; after arrival at 4 -> target 6. Without the macro, `target_o` stays 6.
- Assert `rst_n`=0 during ISSUE -> next cycle all outputs at reset values, `pending_o`=0.
